// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage bus: instruction handshake plus data-memory
// load response. The master modport is the memory-stage side and the slave
// modport is the writeback-stage side.
interface writeback_stage_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic        mem_rd_we;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output mem_valid, mem_rd, mem_rd_we, mem_is_load, mem_funct3,
               mem_addr_lo, mem_alu_result, dmem_rvalid, dmem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_rd, mem_rd_we, mem_is_load, mem_funct3,
               mem_addr_lo, mem_alu_result, dmem_rvalid, dmem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results directly, waits for load data and
// formats byte/halfword/word loads before driving the register-file write port.
// Optional feature: define WB_INSTRET_EN to add the 64-bit wb_instret counter.
//
// state     | meaning
// IDLE      | ready for a new instruction; ALU results retire next cycle
// WAIT_LOAD | load accepted, waiting for dmem_rvalid; memory stage stalled
module writeback_stage (
    input  logic                   clk,
    input  logic                   rst,
    writeback_stage_if.slave       mem_if,
    output logic [4:0]             wb_rd,
    output logic                   wb_wr_en,
    output logic [31:0]            wb_rd_value,
    output logic                   wb_stall,
    output logic                   wb_load_fault
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]            wb_instret
`endif
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        ld_rd_we_q, ld_rd_we_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic [1:0]  ld_addr_lo_q, ld_addr_lo_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_wr_en_q, wb_wr_en_d;
    logic [31:0] wb_rd_value_q, wb_rd_value_d;
    logic        wb_load_fault_q, wb_load_fault_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;
`endif

    // Select the addressed byte and halfword of the returned word.
    always_comb begin
        ld_byte = mem_if.dmem_rdata[7:0];
        case (ld_addr_lo_q)
            2'd0: ld_byte = mem_if.dmem_rdata[7:0];
            2'd1: ld_byte = mem_if.dmem_rdata[15:8];
            2'd2: ld_byte = mem_if.dmem_rdata[23:16];
            2'd3: ld_byte = mem_if.dmem_rdata[31:24];
            default: ld_byte = mem_if.dmem_rdata[7:0];
        endcase
        ld_half = ld_addr_lo_q[1] ? mem_if.dmem_rdata[31:16] : mem_if.dmem_rdata[15:0];
    end

    // Next-state, capture and write-port logic.
    always_comb begin
        state_d         = state_q;
        ld_rd_d         = ld_rd_q;
        ld_rd_we_d      = ld_rd_we_q;
        ld_funct3_d     = ld_funct3_q;
        ld_addr_lo_d    = ld_addr_lo_q;
        wb_rd_d         = wb_rd_q;
        wb_wr_en_d      = 1'b0;
        wb_rd_value_d   = wb_rd_value_q;
        wb_load_fault_d = 1'b0;
        mem_if.mem_ready = (state_q == IDLE);
`ifdef WB_INSTRET_EN
        instret_d       = instret_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_if.mem_valid) begin
`ifdef WB_INSTRET_EN
                    if (!mem_if.mem_is_load) instret_d = instret_q + 64'd1;
`endif
                    if (!mem_if.mem_is_load) begin
                        wb_rd_d       = mem_if.mem_rd;
                        wb_rd_value_d = mem_if.mem_alu_result;
                        wb_wr_en_d    = mem_if.mem_rd_we && (mem_if.mem_rd != 5'd0);
                    end else begin
                        ld_rd_d      = mem_if.mem_rd;
                        ld_rd_we_d   = mem_if.mem_rd_we;
                        ld_funct3_d  = mem_if.mem_funct3;
                        ld_addr_lo_d = mem_if.mem_addr_lo;
                        state_d      = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_if.dmem_rvalid) begin
`ifdef WB_INSTRET_EN
                    instret_d = instret_q + 64'd1;
`endif
                    state_d    = IDLE;
                    wb_rd_d    = ld_rd_q;
                    wb_wr_en_d = ld_rd_we_q && (ld_rd_q != 5'd0);
                    case (ld_funct3_q)
                        3'b000: wb_rd_value_d = {{24{ld_byte[7]}}, ld_byte};
                        3'b001: wb_rd_value_d = {{16{ld_half[15]}}, ld_half};
                        3'b010: wb_rd_value_d = mem_if.dmem_rdata;
                        3'b100: wb_rd_value_d = {24'd0, ld_byte};
                        3'b101: wb_rd_value_d = {16'd0, ld_half};
                        default: begin
                            // Unsupported width: no formatted data exists, so
                            // the value port is zeroed and no write happens.
                            wb_rd_value_d   = 32'd0;
                            wb_wr_en_d      = 1'b0;
                            wb_load_fault_d = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            ld_rd_q         <= 5'd0;
            ld_rd_we_q      <= 1'b0;
            ld_funct3_q     <= 3'd0;
            ld_addr_lo_q    <= 2'd0;
            wb_rd_q         <= 5'd0;
            wb_wr_en_q      <= 1'b0;
            wb_rd_value_q   <= 32'd0;
            wb_load_fault_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ld_rd_q         <= ld_rd_d;
            ld_rd_we_q      <= ld_rd_we_d;
            ld_funct3_q     <= ld_funct3_d;
            ld_addr_lo_q    <= ld_addr_lo_d;
            wb_rd_q         <= wb_rd_d;
            wb_wr_en_q      <= wb_wr_en_d;
            wb_rd_value_q   <= wb_rd_value_d;
            wb_load_fault_q <= wb_load_fault_d;
        end
    end

`ifdef WB_INSTRET_EN
    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) instret_q <= 64'd0;
        else     instret_q <= instret_d;
    end

    assign wb_instret = instret_q;
`endif

    assign wb_rd         = wb_rd_q;
    assign wb_wr_en      = wb_wr_en_q;
    assign wb_rd_value   = wb_rd_value_q;
    assign wb_load_fault = wb_load_fault_q;
    assign wb_stall      = !mem_if.mem_ready;

endmodule
